// File: rtl/apb_alu_slave_if.sv
// APB bus bundle between the ALU test master and the ALU completer.
// The irq level travels with the bus so one handle carries everything.
interface apb_alu_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;
    logic                  irq;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr, irq
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr, irq
    );
endinterface

// File: rtl/apb_alu_slave.sv
// APB completer fronting a single-cycle ALU and a shift-add multiplier.
// Operands, opcode and a 2W-bit result sit behind a 6-word register map.
module apb_alu_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input logic i_PCLK,
    input logic i_PRESET,
    apb_alu_slave_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALU,
        S_MUL
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]   opa, opb, res_lo, res_hi, mul_a;
    logic [2:0]     opcode;
    logic [2*W-1:0] prod, prod_nx;
    logic [W:0]     upper, sum, diff;
    logic [W-1:0]   alu_lo, alu_hi, rdata;
    logic [CW-1:0]  mcnt;
    logic [3:0]     cnt;
    logic [4:0]     off;
    logic done, busy, access, ready, err;
    logic wr_ok, rd_ok, start, mul_last;
    logic unused_ok;

    assign off       = bus.paddr[4:0];
    assign unused_ok = ^bus.paddr[ADDR_WIDTH-1:5];
    assign busy      = state != S_IDLE;
    assign access    = bus.psel & bus.penable;
    assign ready     = access & ~i_PRESET
                     & (cnt == 4'(WAIT_STATES));

    always_comb begin
        err = 1'b0;
        if (off[1:0] != 2'b00 || off >= 5'h18)
            err = 1'b1;
        else if (bus.pwrite) begin
            if (off >= 5'h0C)
                err = 1'b1;
            else if (off == 5'h08 && bus.pwdata[2:0] > 3'd5)
                err = 1'b1;
            else if (busy)
                err = 1'b1;
        end
    end

    assign wr_ok = ready & bus.pwrite & ~err;
    assign rd_ok = ready & ~bus.pwrite & ~err;
    assign start = wr_ok & (off == 5'h08);

    always_comb begin
        rdata = '0;
        unique case (off)
            5'h00:   rdata = opa;
            5'h04:   rdata = opb;
            5'h08:   rdata = W'(opcode);
            5'h0C:   rdata = W'({done, busy});
            5'h10:   rdata = res_lo;
            5'h14:   rdata = res_hi;
            default: rdata = '0;
        endcase
    end

    assign bus.pready  = ready;
    assign bus.pslverr = ready & err;
    assign bus.prdata  = rd_ok ? rdata : '0;
    assign bus.irq     = done;

    // One multiplier bit per cycle: add A into the top half, shift right.
    assign upper    = {1'b0, prod[2*W-1:W]}
                    + (prod[0] ? {1'b0, mul_a} : '0);
    assign prod_nx  = {upper, prod[W-1:1]};
    assign mul_last = mcnt == CW'(W - 1);

    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, opa} - {1'b0, opb};

    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        unique case (opcode)
            3'd0: begin
                alu_lo = sum[W-1:0];
                alu_hi = W'(sum[W]);
            end
            3'd1: begin
                alu_lo = diff[W-1:0];
                alu_hi = W'(diff[W]);
            end
            3'd2:    alu_lo = opa & opb;
            3'd3:    alu_lo = opa | opb;
            3'd4:    alu_lo = opa ^ opb;
            default: alu_lo = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start)
                state_nx = (bus.pwdata[2:0] == 3'd5) ? S_MUL : S_ALU;
            S_ALU:  state_nx = S_IDLE;
            S_MUL:  if (mul_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            opcode <= '0;
            res_lo <= '0;
            res_hi <= '0;
            mul_a  <= '0;
            prod   <= '0;
            mcnt   <= '0;
            done   <= 1'b0;
        end else begin
            cnt <= (!access || ready) ? 4'd0 : cnt + 4'd1;
            if (rd_ok && off == 5'h10) done <= 1'b0;
            if (wr_ok) begin
                if (off == 5'h00) opa <= bus.pwdata;
                if (off == 5'h04) opb <= bus.pwdata;
            end
            if (start) begin
                opcode <= bus.pwdata[2:0];
                done   <= 1'b0;
                mul_a  <= opa;
                prod   <= {{W{1'b0}}, opb};
                mcnt   <= '0;
            end
            if (state == S_ALU) begin
                res_lo <= alu_lo;
                res_hi <= alu_hi;
                done   <= 1'b1;
            end
            if (state == S_MUL) begin
                prod <= prod_nx;
                mcnt <= mcnt + 1'b1;
                if (mul_last) begin
                    res_lo <= prod_nx[W-1:0];
                    res_hi <= prod_nx[2*W-1:W];
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_alu_slave.sv
// Directed bench for apb_alu_slave: one DUT with one wait state and
// one with zero wait states, sharing clock and reset.
module tb_apb_alu_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_alu_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if();
    apb_alu_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_if();

    apb_alu_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(1)
    ) dut_a (
        .i_PCLK(clk), .i_PRESET(rst), .bus(a_if.slave)
    );

    apb_alu_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0)
    ) dut_b (
        .i_PCLK(clk), .i_PRESET(rst), .bus(b_if.slave)
    );

    task automatic drive(input bit sel, input logic ps,
                         input logic pe, input logic wr,
                         input logic [31:0] addr,
                         input logic [31:0] data);
        if (sel) begin
            b_if.psel = ps; b_if.penable = pe; b_if.pwrite = wr;
            b_if.paddr = addr; b_if.pwdata = data;
        end else begin
            a_if.psel = ps; a_if.penable = pe; a_if.pwrite = wr;
            a_if.paddr = addr; a_if.pwdata = data;
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Returns just after the edge that ends the PREADY cycle.
    task automatic xfer(input bit sel, input logic wr,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rd,
                        output logic err, output int waits);
        logic rdy;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, wr, addr, wdata);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, wr, addr, wdata);
        waits = 0;
        #1 rdy = sel ? b_if.pready : a_if.pready;
        while (!rdy && waits < 20) begin
            @(negedge clk);
            #1 rdy = sel ? b_if.pready : a_if.pready;
            waits++;
        end
        if (!rdy) begin
            vectors++; miscompares++;
            $display("FAIL pready_timeout addr %h", addr);
        end
        rd  = sel ? b_if.prdata : a_if.prdata;
        err = sel ? b_if.pslverr : a_if.pslverr;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        vectors++;
        if (a_if.pready !== 1'b0 || a_if.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_a got rdy %b irq %b exp 0 0",
                     a_if.pready, a_if.irq);
        end
        vectors++;
        if (b_if.pready !== 1'b0 || b_if.prdata !== 32'h0
            || b_if.pslverr !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_b got rdy %b data %h err %b exp 0",
                     b_if.pready, b_if.prdata, b_if.pslverr);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_add();
        logic [31:0] rd; logic err; int w;
        logic [31:0] adr [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] dat [3] = '{32'hFFFF_FFFF, 32'h2, 32'h0};
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 1'b1, adr[i], dat[i], rd, err, w);
            vectors++;
            if (w !== 1 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL add_wr%0d got waits %0d err %b exp 1 0",
                         i, w, err);
            end
        end
        xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h2 || a_if.irq !== 1'b1) begin
            miscompares++;
            $display("FAIL add_status got %h irq %b exp 2 1",
                     rd, a_if.irq);
        end
        xfer(1'b0, 1'b0, 32'h14, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL add_res_hi got %h exp 1", rd);
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL add_res_lo got %h exp 1", rd);
        end
        xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (rd !== 32'h0 || a_if.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL add_done_clr got %h irq %b exp 0 0",
                     rd, a_if.irq);
        end
    endtask

    task automatic test_sub();
        logic [31:0] rd; logic err; int w;
        xfer(1'b0, 1'b1, 32'h0, 32'h3, rd, err, w);
        xfer(1'b0, 1'b1, 32'h4, 32'h5, rd, err, w);
        xfer(1'b0, 1'b1, 32'h8, 32'h1, rd, err, w);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL sub_res_lo got %h exp fffffffe", rd);
        end
        xfer(1'b0, 1'b0, 32'h14, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL sub_res_hi got %h exp 1", rd);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] rd; logic err; int w;
        xfer(1'b0, 1'b1, 32'h0, 32'h5, rd, err, w);
        xfer(1'b0, 1'b1, 32'h4, 32'h7, rd, err, w);
        xfer(1'b0, 1'b1, 32'h8, 32'h5, rd, err, w);
        bus_idle();
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        test_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_status got %h exp 0", rd);
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_res_lo got %h exp 0", rd);
        end
        xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_opa got %h exp 0", rd);
        end
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (a_if.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mul_abandon got irq %b exp 0",
                     a_if.irq);
        end
    endtask

    task automatic test_mul();
        logic [31:0] rd; logic err; int w; int n;
        xfer(1'b0, 1'b1, 32'h0, 32'h0001_0000, rd, err, w);
        xfer(1'b0, 1'b1, 32'h4, 32'h0003_0000, rd, err, w);
        xfer(1'b0, 1'b1, 32'h8, 32'h5, rd, err, w);
        bus_idle();
        n = 0;
        while (a_if.irq !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        vectors++;
        if (n !== 32) begin
            miscompares++;
            $display("FAIL mul_latency got %0d exp 32", n);
        end
        xfer(1'b0, 1'b0, 32'h14, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h3) begin
            miscompares++;
            $display("FAIL mul_res_hi got %h exp 3", rd);
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL mul_res_lo got %h exp 0", rd);
        end
    endtask

    task automatic test_logic();
        logic [31:0] rd; logic err; int w;
        logic [31:0] exp_lo [3] =
            '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34};
        xfer(1'b0, 1'b1, 32'h0, 32'hF0F0_1234, rd, err, w);
        xfer(1'b0, 1'b1, 32'h4, 32'h0FF0_FF00, rd, err, w);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 1'b1, 32'h8, 32'(i + 2), rd, err, w);
            xfer(1'b0, 1'b0, 32'h14, 32'h0, rd, err, w);
            vectors++;
            if (rd !== 32'h0) begin
                miscompares++;
                $display("FAIL logic%0d_hi got %h exp 0", i + 2, rd);
            end
            xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
            vectors++;
            if (rd !== exp_lo[i]) begin
                miscompares++;
                $display("FAIL logic%0d_lo got %h exp %h",
                         i + 2, rd, exp_lo[i]);
            end
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int w;
        xfer(1'b0, 1'b1, 32'h0, 32'h0F0F_0000, rd, err, w);
        xfer(1'b0, 1'b1, 32'h4, 32'h00FF_00FF, rd, err, w);
        xfer(1'b0, 1'b1, 32'h8, 32'h4, rd, err, w);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h0FF0_00FF) begin
            miscompares++;
            $display("FAIL b2b_xor got %h exp 0ff000ff", rd);
        end
        xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_status got %h exp 0", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int w; int polls;
        xfer(1'b0, 1'b0, 32'h18, 32'h0, rd, err, w);
        vectors++;
        if (err !== 1'b1 || rd !== 32'h0 || w !== 1) begin
            miscompares++;
            $display("FAIL err_rd18 got err %b data %h waits %0d",
                     err, rd, w);
        end
        xfer(1'b0, 1'b0, 32'h2, 32'h0, rd, err, w);
        vectors++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL err_rd02 got err %b data %h exp 1 0",
                     err, rd);
        end
        xfer(1'b0, 1'b1, 32'h10, 32'h1234, rd, err, w);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wr_res got err %b exp 1", err);
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h0FF0_00FF || err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_res_kept got %h exp 0ff000ff", rd);
        end
        xfer(1'b0, 1'b1, 32'h8, 32'h6, rd, err, w);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_op6 got err %b exp 1", err);
        end
        xfer(1'b0, 1'b0, 32'h8, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h4) begin
            miscompares++;
            $display("FAIL err_ctrl_kept got %h exp 4", rd);
        end
        xfer(1'b0, 1'b1, 32'h0, 32'h7, rd, err, w);
        xfer(1'b0, 1'b1, 32'h4, 32'h9, rd, err, w);
        xfer(1'b0, 1'b1, 32'h8, 32'h5, rd, err, w);
        xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL busy_status got %h exp 1", rd);
        end
        xfer(1'b0, 1'b1, 32'h0, 32'hDEAD, rd, err, w);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wr_busy got err %b exp 1", err);
        end
        xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h7 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_opa got %h err %b exp 7 0", rd, err);
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        vectors++;
        if (rd !== 32'h0FF0_00FF) begin
            miscompares++;
            $display("FAIL busy_res_old got %h exp 0ff000ff", rd);
        end
        polls = 0;
        rd = 32'h0;
        while (rd !== 32'h2 && polls < 40) begin
            xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, err, w);
            polls++;
        end
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (rd !== 32'd63) begin
            miscompares++;
            $display("FAIL busy_mul_res got %h exp 3f", rd);
        end
    endtask

    task automatic test_ws0();
        logic [31:0] rd; logic err; int w;
        xfer(1'b1, 1'b1, 32'h4, 32'hA5A5_A5A5, rd, err, w);
        vectors++;
        if (w !== 0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL ws0_wr got waits %0d err %b exp 0 0",
                     w, err);
        end
        xfer(1'b1, 1'b0, 32'h4, 32'h0, rd, err, w);
        bus_idle();
        vectors++;
        if (w !== 0 || rd !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL ws0_rd got waits %0d data %h exp 0 a5a5a5a5",
                     w, rd);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk) rst = 1'b0;
        test_add();
        test_sub();
        test_reset_mid_mul();
        test_mul();
        test_logic();
        test_back_to_back();
        test_errors();
        test_ws0();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_alu_slave.md
Name: apb_alu_slave

Overview:
- APB (AMBA 3) completer that puts an ALU behind a small register map. It is the responder end of the bus that APB_master drives.
- The initiator writes the operands and an opcode. The block computes the result, either in a single cycle or with an iterative multiply.
- The initiator polls STATUS, or waits on o_irq, and then reads RESULT.
- It sits on one PSEL line of the APB interconnect, next to the master in the ALU test system.

Parameters:
- ADDR_WIDTH, 32, PADDR width; only PADDR[4:0] is decoded.
- DATA_WIDTH, 32, operand/PWDATA/PRDATA width; must be ≥8.
- WAIT_STATES, 1, number of PREADY-low access cycles before completion (0..15).

Ports:
- i_PCLK  in  1  APB clock; all logic on the rising edge.
- i_PRESET  in  1  synchronous, active-high reset.
- i_PSEL  in  1  slave select.
- i_PENABLE  in  1  access phase.
- i_PWRITE  in  1  1 = write, 0 = read.
- i_PADDR  in  ADDR_WIDTH  byte address.
- i_PWDATA  in  DATA_WIDTH  write data.
- o_PREADY  out  1  transfer completes this cycle.
- o_PRDATA  out  DATA_WIDTH  read data; valid while o_PREADY=1 on a read.
- o_PSLVERR  out  1  transfer error; valid only while o_PREADY=1.
- o_irq  out  1  level; equals STATUS.done.

Behaviour:
- Reset (i_PRESET=1 at a clock edge):
  - Outputs: o_PREADY=0, o_PRDATA=0, o_PSLVERR=0, o_irq=0.
  - Registers OPA, OPB, RES_LO, RES_HI and OPCODE are 0; wait counter is 0; busy=0, done=0.
  - An operation or transfer in progress when reset is applied is abandoned. No write commits from that cycle.
- Register map (offset = PADDR[4:0]):
  - 0x00 OPA, R/W.
  - 0x04 OPB, R/W.
  - 0x08 CTRL, W/R:
    - A write with [2:0]=opcode starts an operation.
    - A read returns the last opcode.
  - 0x0C STATUS, RO: [0]=busy, [1]=done, other bits 0.
  - 0x10 RES_LO, RO.
  - 0x14 RES_HI, RO.
- Wait states:
  - Access phase = i_PSEL & i_PENABLE. The wait counter increments each access cycle while below WAIT_STATES.
  - o_PREADY = access & (cnt==WAIT_STATES). This is combinational from the counter, so WAIT_STATES=0 gives a zero-wait access.
  - The counter clears on the cycle o_PREADY=1 and whenever the block is not in an access phase.
  - A setup phase alone (PSEL=1, PENABLE=0) has no effect.
- Commit: a write updates its register at the edge ending the o_PREADY=1 cycle. Read data comes from register values in that cycle.
- o_PSLVERR=1 with o_PREADY=1 for each of these:
  - PADDR[1:0]!=0.
  - Offset ≥ 0x18.
  - A write to STATUS, RES_LO or RES_HI.
  - A CTRL write with opcode 6 or 7.
  - A write to OPA, OPB or CTRL while busy=1.
- On an errored transfer:
  - No register changes.
  - On a read, o_PRDATA=0.
  - The wait-state count is unchanged.
- Opcodes (W = DATA_WIDTH):
  - 0 ADD: RES_LO=A+B, RES_HI={0,carry}.
  - 1 SUB: RES_LO=A−B mod 2^W, RES_HI={0,borrow(A<B)}.
  - 2 AND, 3 OR, 4 XOR: RES_HI=0.
  - 5 MUL: unsigned A×B, 2W-bit product {RES_HI,RES_LO}.
- Start (accepted CTRL write):
  - At the commit edge, busy←1 and done←0. A new start also clears a previous done.
  - Ops 0–4: result registers load and busy←0, done←1 on the next edge, i.e. done is visible 1 cycle after commit.
  - MUL: shift-add, one bit of B per cycle, operands latched at start. Result and done←1 appear W cycles after commit; busy stays 1 throughout.
- done clears on:
  - a successful read of RES_LO, at the commit edge of that read;
  - a new start.
- Reads during busy:
  - Reads of any register while busy are legal and return current values.
  - RES_LO/RES_HI return the previous result until done rises.
- Simultaneous events: if done rises on the same edge as an RES_LO read commit, the new done wins (stays 1).
- Back-to-back transfers (PSEL held, master returns to setup) are handled with no idle cycle required.

Test Plan:
- Reset:
  - Stimulus: assert i_PRESET for 2 cycles mid-MUL.
  - Response: STATUS=0x0, RES_LO=0, o_irq=0, o_PREADY=0.
- ADD:
  - Stimulus: WAIT_STATES=1; write OPA=0xFFFFFFFF, OPB=0x00000002, CTRL=0.
  - Response: each transfer has exactly 1 PREADY-low cycle. STATUS=0x2, RES_LO=0x00000001, RES_HI=0x1, o_irq=1. Reading RES_LO clears done, so STATUS then reads 0x0.
- SUB:
  - Stimulus: OPA=3, OPB=5, CTRL=1.
  - Response: RES_LO=0xFFFFFFFE, RES_HI=1.
- MUL:
  - Stimulus: OPA=0x10000, OPB=0x30000, CTRL=5; poll STATUS.
  - Response: busy=1 for 32 cycles; then RES_HI=0x3, RES_LO=0x0, done=1.
- Errors — each of the following gives PSLVERR=1 and no state change:
  - read 0x18;
  - read 0x02;
  - write RES_LO;
  - CTRL=6;
  - write OPA during MUL busy (OPA reads back unchanged).
- WAIT_STATES=0:
  - Stimulus: consecutive write/read of OPB=0xA5A5A5A5.
  - Response: PREADY=1 in the first access cycle; read returns 0xA5A5A5A5.
